// File: rtl/draw_interrgen_pkg.sv
// Shared types and status-bit layout for the draw-engine interrupt/error generator.
// Layout of the status word: [0] internal error, then one bit per code source, then one per bound checker.
package draw_interrgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int ST_IERR     = 0;
  localparam int ST_SRC_BASE = 1;

  function automatic int st_bnd_base(input int nsrc);
    return 1 + nsrc;
  endfunction

  function automatic int st_width(input int nsrc, input int nbound);
    return 1 + nsrc + nbound;
  endfunction

endpackage

// File: rtl/draw_sticky_reg.sv
// Sticky status register: set bits accumulate, host clears by write-one, init clears all.
// new_o flags bits rising 0->1 at this edge; a set in the same cycle beats a clear.
module draw_sticky_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init_clr_i,
  input  logic [W-1:0] set_i,
  input  logic [W-1:0] clr_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] nxt_o,
  output logic [W-1:0] new_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    if (init_clr_i) q_d = '0;
    else            q_d = (q_q & ~clr_i) | set_i;
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o   = q_q;
  assign nxt_o = q_d;
  assign new_o = init_clr_i ? '0 : (set_i & ~q_q);

endmodule

// File: rtl/draw_interrgen_n.sv
// Drawing-engine interrupt/error generator: sticky error status, masked IRQs, re-init sequencer.
// Build option DRW_IRQ_LEVEL_EN: interrupts held until INT_ACK instead of 1-cycle pulses.
module draw_interrgen_n
  import draw_interrgen_pkg::*;
#(
  parameter int NSRC     = 4,
  parameter int CODE_W   = 4,
  parameter int NBOUND   = 3,
  parameter int INIT_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic                            CLK,
  input  logic                            RST_X,
  input  logic                            INITCMND,
  input  logic                            EODL,
  input  logic [NSRC*CODE_W-1:0]          ECODE,
  input  logic [NBOUND-1:0]               OVER,
  input  logic [NBOUND-1:0]               UNDER,
  input  logic                            WORKING_VRAM,
  input  logic                            MASK_WE,
  input  logic                            CLR_WE,
  input  logic [NSRC+NBOUND:0]            HOST_WD,
  input  logic                            INT_ACK,
  output logic [NSRC+NBOUND-1:0]          INIT_OUT,
  output logic [NSRC+NBOUND+CODE_W:0]     ERROR_REG,
  output logic [CNT_W-1:0]                ERR_COUNT,
  output logic                            DRW_ERRINT,
  output logic                            DRW_INT,
  output logic                            BUSY,
  output logic                            WORKINGDRW
);

  localparam int ST_W = st_width(NSRC, NBOUND);
  localparam int BND  = st_bnd_base(NSRC);
  localparam int IC_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [IC_W-1:0]  IC_LAST = IC_W'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [IC_W-1:0]   icnt_q, icnt_d;
  logic              start;

  assign start = INITCMND | EODL;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= IDLE;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
    end
  end

  // NOTE: defaulting every combinational output first keeps the block free of inferred latches.
  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    case (state_q)
      IDLE: if (start) begin state_d = INIT; icnt_d = '0; end
      INIT: begin
        if (start)                 icnt_d  = '0;
        else if (icnt_q == IC_LAST) state_d = RUN;
        else                       icnt_d  = icnt_q + 1'b1;
      end
      RUN:  if (start) begin state_d = INIT; icnt_d = '0; end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY     = (state_q == INIT);
    INIT_OUT = BUSY ? '1 : '0;
  end

  assign WORKINGDRW = WORKING_VRAM;

  // Error inputs are blanked while sub-units are being re-initialised.
  logic [ST_W-1:0]   raw_st;
  logic [CODE_W-1:0] raw_code;
  always_comb begin
    raw_st   = '0;
    raw_code = '0;
    for (int i = 0; i < NSRC; i++) begin
      raw_st[ST_SRC_BASE+i] = |ECODE[i*CODE_W +: CODE_W];
      raw_code              = raw_code | ECODE[i*CODE_W +: CODE_W];
    end
    for (int j = 0; j < NBOUND; j++) raw_st[BND+j] = OVER[j] | UNDER[j];
    raw_code[0] = raw_code[0] | (|UNDER);
    raw_code[1] = raw_code[1] | (|OVER);
    if (BUSY) begin
      raw_st   = '0;
      raw_code = '0;
    end
  end

  logic [ST_W-1:0] st_q, st_nxt, st_new;

  draw_sticky_reg #(.W(ST_W)) u_status (
    .clk        (CLK),
    .rst_n      (RST_X),
    .init_clr_i (INITCMND),
    .set_i      (raw_st),
    .clr_i      (CLR_WE ? HOST_WD : '0),
    .q_o        (st_q),
    .nxt_o      (st_nxt),
    .new_o      (st_new)
  );

  logic [CODE_W-1:0] code_q, code_d;
  logic [ST_W-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              any_q, raw_any, err_ev;
  logic              errint_q, errint_d, int_q, int_d;

  assign raw_any = |raw_st;
  assign err_ev  = |(st_new & ~mask_q);

  always_comb begin
    mask_d = MASK_WE ? HOST_WD : mask_q;
    if (INITCMND || (st_nxt == '0)) code_d = '0;
    else                            code_d = code_q | raw_code;
    if (INITCMND)                                        cnt_d = '0;
    else if (raw_any && !any_q && (cnt_q != CNT_MAX))    cnt_d = cnt_q + 1'b1;
    else                                                 cnt_d = cnt_q;
  end

`ifdef DRW_IRQ_LEVEL_EN
  always_comb begin
    if (INITCMND)     errint_d = 1'b0;
    else if (err_ev)  errint_d = 1'b1;
    else if (INT_ACK) errint_d = 1'b0;
    else              errint_d = errint_q;
    if (INITCMND)     int_d = 1'b0;
    else if (EODL)    int_d = 1'b1;
    else if (INT_ACK) int_d = 1'b0;
    else              int_d = int_q;
  end
`else
  logic unused_int_ack;
  assign unused_int_ack = INT_ACK;
  always_comb begin
    errint_d = err_ev;
    int_d    = EODL & ~INITCMND;
  end
`endif

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      code_q   <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      any_q    <= 1'b0;
      errint_q <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      code_q   <= code_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      any_q    <= raw_any;
      errint_q <= errint_d;
      int_q    <= int_d;
    end
  end

  assign ERROR_REG  = {st_q, code_q};
  assign ERR_COUNT  = cnt_q;
  assign DRW_ERRINT = errint_q;
  assign DRW_INT    = int_q;

endmodule

// File: doc/draw_interrgen_n.md
Name: draw_interrgen_n

Overview:
Parametrised drawing-engine interrupt/error generator for NSRC error-code sources and NBOUND address-bound checkers. It aggregates error codes into a sticky status register and emits masked error-interrupt and end-of-display-list interrupts. It sequences a multi-cycle re-init of sub-units and keeps a saturating error-event counter. Sits between the draw pipeline (REG/ADD/PIXEL/VRAM units, SRC/DST/WR bound checkers) and the host register block.

Parameters:
NSRC, 4, number of error-code sources
CODE_W, 4, error-code width per source (>=2)
NBOUND, 3, number of bound checkers (OVER/UNDER pairs)
INIT_CYC, 2, cycles INIT_OUT is held (>=1)
CNT_W, 8, error-event counter width

Ports:
CLK  in  1  clock
RST_X  in  1  asynchronous active-low reset
INITCMND  in  1  host init command, active high
EODL  in  1  end of display list, active high
ECODE  in  NSRC*CODE_W  error codes; source i at [i*CODE_W +: CODE_W]
OVER  in  NBOUND  bound overflow flags
UNDER  in  NBOUND  bound underflow flags
WORKING_VRAM  in  1  VRAM unit busy
MASK_WE  in  1  write strobe for IRQ mask
CLR_WE  in  1  write strobe for status clear
HOST_WD  in  ST_W  write data (ST_W = 1+NSRC+NBOUND)
INT_ACK  in  1  interrupt acknowledge
INIT_OUT  out  NSRC+NBOUND  init strobe to each sub-unit
ERROR_REG  out  ST_W+CODE_W  {status, sticky code}
ERR_COUNT  out  CNT_W  saturating error-event count
DRW_ERRINT  out  1  error interrupt
DRW_INT  out  1  end-of-list interrupt
BUSY  out  1  high while in INIT
WORKINGDRW  out  1  = WORKING_VRAM (combinational)

Behaviour:
- Reset: all registers 0. INIT_OUT=0, ERROR_REG=0, ERR_COUNT=0, DRW_ERRINT=0, DRW_INT=0, BUSY=0, mask=0 (all enabled), FSM=IDLE.
- FSM IDLE->INIT on INITCMND|EODL. In INIT: INIT_OUT all ones, BUSY=1, counter runs INIT_CYC cycles, then ->RUN. RUN->INIT on INITCMND|EODL. INITCMND or EODL while in INIT restarts the counter.
- Raw status (per cycle): bit0 = 0 (reserved internal error); bit 1+i = |ECODE_i; bit 1+NSRC+j = OVER[j]|UNDER[j].
- Raw code: bitwise OR of all ECODE_i; bit0 also ORs all UNDER, bit1 also ORs all OVER.
- Sticky: status and code registers OR in raw values each edge. Error inputs are ignored while in INIT.
- CLR_WE clears status bits where HOST_WD=1. The code register clears when the status becomes all-zero. A set in the same cycle wins over a clear.
- INITCMND clears status, code, counter and both interrupts. This has priority over everything. EODL does not clear status.
- MASK_WE loads mask from HOST_WD. Mask bit 1 suppresses the interrupt for that status bit. It does not suppress the sticky bit.
- DRW_ERRINT (registered): a "new event" is any status bit going 0->1 at this edge with mask=0. The event is visible in the same cycle as the sticky bit, i.e. 1 cycle after the input is sampled.
- DRW_INT (registered): asserted the cycle after EODL is sampled.
- ERR_COUNT: +1 on each edge where raw any-error rises 0->1. Saturates at 2^CNT_W-1.
- WORKINGDRW: pass-through.

Optional Feature:
DRW_IRQ_LEVEL_EN
- Defined: DRW_ERRINT and DRW_INT are level outputs. Each is held from its event until INT_ACK, or until INITCMND. An event coinciding with INT_ACK keeps the output high.
- Undefined: both are 1-cycle pulses, and INT_ACK is ignored.

Decomposition:
- Package draw_interrgen_pkg: FSM state typedef (IDLE, INIT, RUN) and status bit-index constants (ST_IERR=0, ST_SRC_BASE=1, ST_BND_BASE=1+NSRC) as functions of the parameters.
- One sub-module, draw_sticky_reg: ST_W-wide set/W1C/init-clear sticky register with new-bit detect. It is instantiated for status.

Test Plan:
- Reset then INITCMND 1 cycle -> BUSY=1 and INIT_OUT=all ones for exactly 2 cycles, then BUSY=0; ERROR_REG=0.
- Default params, ECODE src2=4'b0100 for 1 cycle -> next cycle ERROR_REG=12'b0000_1000_0100; DRW_ERRINT one pulse; ERR_COUNT=1; the same error repeated produces no further pulse.
- OVER[1]=1 with mask bit 6 set -> status bit6=1, code bit1=1, DRW_ERRINT stays 0.
- CLR_WE with HOST_WD=bit6 while OVER[1]=1 in the same cycle -> bit6 stays 1. Next cycle with no error, clear -> ERROR_REG=0.
- EODL pulse -> DRW_INT=1 next cycle, INIT sequence runs, status retained. With DRW_IRQ_LEVEL_EN, DRW_INT holds until INT_ACK.
- 300 error rising edges with CNT_W=8 -> ERR_COUNT saturates at 255. INITCMND -> 0.
